// File: rtl/csr_unit.sv
// Control/status register file: exception entry/return bookkeeping,
// interrupt status and enables, and a down-counting timer.
module csr_unit #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    logic [4:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] ecfg_lie;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_ti;
    logic        is_ipi;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] era;
    logic [25:0] eentry;
    logic [31:0] save [4];
    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] tval;

    // Reads are always combinational; the read enable carries no information here.
    logic unused_csr_re;
    assign unused_csr_re = csr_re;

    logic        sw_we;
    logic [31:0] wbits;
    logic [31:0] keep;
    assign sw_we = csr_we & ~wb_ex & ~ertn_flush;
    assign wbits = csr_wvalue & csr_wmask;
    assign keep  = ~csr_wmask;

    logic [4:0]  crmd_m;
    logic [2:0]  prmd_m;
    logic [12:0] ecfg_m;
    logic [1:0]  is_sw_m;
    logic [31:0] era_m;
    logic [25:0] eentry_m;
    logic [31:0] save_m;
    logic [31:0] tid_m;
    logic [31:0] tcfg_m;
    assign crmd_m   = wbits[4:0]   | (crmd     & keep[4:0]);
    assign prmd_m   = wbits[2:0]   | (prmd     & keep[2:0]);
    assign ecfg_m   = (wbits[12:0] | (ecfg_lie & keep[12:0])) & 13'h1BFF;
    assign is_sw_m  = wbits[1:0]   | (is_sw    & keep[1:0]);
    assign era_m    = wbits        | (era      & keep);
    assign eentry_m = wbits[31:6]  | (eentry   & keep[31:6]);
    assign save_m   = wbits        | (save[csr_num[1:0]] & keep);
    assign tid_m    = wbits        | (tid      & keep);
    assign tcfg_m   = wbits        | (tcfg     & keep);

    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_eentry;
    logic wr_save, wr_tid, wr_tcfg, wr_ticlr;
    assign wr_crmd   = sw_we && (csr_num == CSR_CRMD);
    assign wr_prmd   = sw_we && (csr_num == CSR_PRMD);
    assign wr_ecfg   = sw_we && (csr_num == CSR_ECFG);
    assign wr_estat  = sw_we && (csr_num == CSR_ESTAT);
    assign wr_era    = sw_we && (csr_num == CSR_ERA);
    assign wr_eentry = sw_we && (csr_num == CSR_EENTRY);
    assign wr_save   = sw_we && (csr_num[13:2] == CSR_SAVE0[13:2]);
    assign wr_tid    = sw_we && (csr_num == CSR_TID);
    assign wr_tcfg   = sw_we && (csr_num == CSR_TCFG);
    assign wr_ticlr  = sw_we && (csr_num == CSR_TICLR) && wbits[0];

    // A fresh TCFG write reloads the counter, so it also pre-empts a pending expiry.
    logic timer_fire;
    assign timer_fire = tcfg[0] && (tval == 32'd1) && !wr_tcfg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd <= 5'b01000;
            prmd <= 3'b000;
            era  <= 32'h0;
        end else if (wb_ex) begin
            prmd      <= crmd[2:0];
            crmd[2:0] <= 3'b000;
            era       <= wb_pc;
        end else if (ertn_flush) begin
            crmd[2:0] <= prmd;
        end else begin
            if (wr_crmd) crmd <= crmd_m;
            if (wr_prmd) prmd <= prmd_m;
            if (wr_era)  era  <= era_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecfg_lie <= '0;
            eentry   <= '0;
            tid      <= TID_RESET;
            for (int i = 0; i < 4; i++) save[i] <= '0;
        end else begin
            if (wr_ecfg)   ecfg_lie <= ecfg_m;
            if (wr_eentry) eentry   <= eentry_m;
            if (wr_tid)    tid      <= tid_m;
            if (wr_save)   save[csr_num[1:0]] <= save_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_sw    <= '0;
            is_hw    <= '0;
            is_ipi   <= 1'b0;
            is_ti    <= 1'b0;
            ecode    <= '0;
            esubcode <= '0;
        end else begin
            is_hw  <= hw_int_in;
            is_ipi <= ipi_int_in;
            if (wr_estat) is_sw <= is_sw_m;
            if (wb_ex) begin
                ecode    <= wb_ecode;
                esubcode <= wb_esubcode;
            end
            if (timer_fire)     is_ti <= 1'b1;
            else if (wr_ticlr)  is_ti <= 1'b0;
        end
    end

    // One-shot mode parks at zero; periodic mode reloads one cycle after reaching it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg <= '0;
            tval <= 32'hFFFF_FFFF;
        end else if (wr_tcfg) begin
            tcfg <= tcfg_m;
            tval <= {tcfg_m[31:2], 2'b00};
        end else if (tcfg[0]) begin
            if (tval != 32'd0)  tval <= tval - 32'd1;
            else if (tcfg[1])   tval <= {tcfg[31:2], 2'b00};
        end
    end

    logic [12:0] estat_is;
    assign estat_is = {is_ipi, is_ti, 1'b0, is_hw, is_sw};

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            CSR_CRMD:   csr_rvalue = {27'b0, crmd};
            CSR_PRMD:   csr_rvalue = {29'b0, prmd};
            CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
            CSR_ESTAT:  csr_rvalue = {1'b0, esubcode, ecode, 3'b000, estat_is};
            CSR_ERA:    csr_rvalue = era;
            CSR_EENTRY: csr_rvalue = {eentry, 6'b0};
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        csr_rvalue = save[csr_num[1:0]];
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = tcfg;
            CSR_TVAL:   csr_rvalue = tval;
            default:    csr_rvalue = 32'h0;
        endcase
    end

    assign has_int  = crmd[2] & (|(estat_is & ecfg_lie));
    assign ex_entry = {eentry, 6'b0};
    assign ertn_pc  = era;

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter: TID_RESET, default 32'h0, meaning TID reset value.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 csr_re  input  1  read enable from ID/EX CSR instructions; readout is combinational regardless.
REQ-005 csr_num  input  14  CSR address for read and write.
REQ-006 csr_rvalue  output  32  read data for csr_num.
REQ-007 csr_we  input  1  write enable, asserted in WB for csrwr/csrxchg.
REQ-008 csr_wmask  input  32  bit write mask (all ones for csrwr).
REQ-009 csr_wvalue  input  32  write data.
REQ-010 wb_ex  input  1  exception commit from WB (driven by WB excp_flush).
REQ-011 wb_ecode  input  6  exception code.
REQ-012 wb_esubcode  input  9  exception subcode.
REQ-013 wb_pc  input  32  faulting PC (WB debug_wb_pc).
REQ-014 ertn_flush  input  1  ertn commit from WB.
REQ-015 hw_int_in  input  8  hardware interrupt lines; ipi_int_in  input  1  inter-processor interrupt.
REQ-016 ex_entry  output  32  EENTRY value (fetch redirect on exception); ertn_pc  output  32  ERA value.
REQ-017 has_int  output  1  interrupt pending and enabled.

Function
REQ-018 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44; any other address reads 32'h0, writes ignored.
REQ-019 Fields: CRMD PLV[1:0] IE[2] DA[3] PG[4], rest 0; PRMD PPLV[1:0] PIE[2]; ECFG LIE[9:0],[12:11], bit10 and [31:13] read 0; ESTAT IS[12:0] (bit10 reads 0), Ecode[21:16], EsubCode[30:22]; EENTRY VA[31:6], [5:0] read 0; TCFG En[0] Periodic[1] InitV[31:2]; TICLR reads 0.
REQ-020 Write: field <= (wvalue & wmask) | (field & ~wmask), only software-writable bits; ESTAT writable bits IS[1:0] only; TVAL read-only; result visible on csr_rvalue the next cycle (1-cycle latency).
REQ-021 wb_ex: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=wb_pc, ESTAT.Ecode<=wb_ecode, ESTAT.EsubCode<=wb_esubcode, all in one cycle.
REQ-022 ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; PRMD, ERA unchanged.
REQ-023 Priority: wb_ex > ertn_flush > csr_we; in a cycle with wb_ex or ertn_flush high, csr_we is ignored entirely.
REQ-024 ESTAT.IS[9:2] <= hw_int_in every cycle; IS[12] <= ipi_int_in every cycle.
REQ-025 TCFG write: TVAL <= {new InitV, 2'b00} same edge; TCFG write with En=0 stops counting, TVAL holds.
REQ-026 Timer: when En=1 and TVAL!=0, TVAL decrements by 1 per cycle; on 1->0 transition IS[11] <= 1.
REQ-027 TVAL==0 with En=1: Periodic=1 reloads {InitV,2'b00} next cycle and continues; Periodic=0 holds 0, no further IS[11] sets.
REQ-028 TICLR write with masked bit0=1 clears IS[11]; if timer sets IS[11] the same cycle, set wins.
REQ-029 has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational.
REQ-030 ex_entry = EENTRY, ertn_pc = ERA, combinational.

Reset
REQ-031 On resetn low (asynchronous): CRMD=32'h8 (DA=1, PLV=0, IE=0), PRMD=0, ECFG=0, ESTAT=0, TCFG=0 (En=0), TVAL=32'hFFFFFFFF, TID=TID_RESET; ERA, EENTRY, SAVE0-3 reset to 0.
REQ-032 Outputs during reset: has_int=0, ex_entry=0, ertn_pc=0, csr_rvalue per reset state; reset mid-count stops timer immediately.

Verification
REQ-033 Write EENTRY=32'h1C00_8000, then wb_ex with wb_pc=32'h1C00_0100, ecode=6'hB, CRMD.PLV=3/IE=1 -> next cycle ERA=32'h1C00_0100, ESTAT[21:16]=6'hB, CRMD[2:0]=0, PRMD[2:0]=3'b111, ex_entry=32'h1C00_8000.
REQ-034 After REQ-033, ertn_flush -> CRMD[2:0]=3'b111, ertn_pc=32'h1C00_0100.
REQ-035 TCFG write 32'h0000_000B (InitV=2, periodic, En) -> TVAL=8, reaches 0 after 8 cycles, IS[11]=1; reload to 8 next cycle; TICLR write 1 -> IS[11]=0.
REQ-036 ECFG.LIE[2]=1, CRMD.IE=1, hw_int_in=8'h01 -> has_int=1 after 1 cycle; CRMD.IE=0 -> has_int=0.
REQ-037 wb_ex and csr_we to CRMD (value 32'h7) same cycle -> CRMD.PLV=0, IE=0; csr_we ignored.
REQ-038 csrxchg SAVE0 with wmask=32'h0000_FFFF, wvalue=32'h1234_5678 over 32'hAAAA_AAAA -> SAVE0=32'hAAAA_5678; read 0x7FF -> 32'h0.
